// File: rtl/sap_mem_arbiter.sv
// Shares the SAP 16x8 program RAM between the running CPU and an external loader.
// Parks the CPU at an instruction boundary, serves four-phase loader transactions, restarts from 0.
module sap_mem_arbiter (
    input  logic       clk,
    input  logic       clr,
    input  logic       prog_mode,
    input  logic       ext_req,
    input  logic       ext_we,
    input  logic [3:0] ext_addr,
    input  logic [7:0] ext_wdata,
    output logic       ext_ack,
    output logic [7:0] ext_rdata,
    input  logic [3:0] cpu_addr,
    input  logic       cpu_ce_n,
    input  logic       cpu_last,
    input  logic       cpu_hlt_n,
    output logic       cpu_run_en,
    output logic       cpu_clr,
    output logic [3:0] ram_addr,
    output logic       ram_ce_n,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       prog_active,
    output logic [4:0] wr_count
);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_IDLE,
        S_WR,
        S_RD,
        S_ACK,
        S_RESTART
    } state_t;

    localparam logic [4:0] WR_COUNT_MAX = 5'd16;

    state_t     state_q, state_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic [7:0] rdata_q, rdata_d;
    logic [4:0] wr_count_q, wr_count_d;

    // Moore outputs, registered from the next state so they are glitch-free.
    logic       run_en_q;
    logic       cpu_clr_q;
    logic       prog_active_q;
    logic       ack_q;
    logic       ram_we_q;
    logic       ram_rd_q;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        wr_count_d = wr_count_q;

        case (state_q)
            S_RUN: begin
                if (prog_mode) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // The CPU completes the edge that samples its last T-state and parks at T1.
                if (cpu_last || !cpu_hlt_n) begin
                    state_d    = S_IDLE;
                    wr_count_d = '0;
                end
            end
            S_IDLE: begin
                if (ext_req) begin
                    addr_d  = ext_addr;
                    wdata_d = ext_wdata;
                    we_d    = ext_we;
                    state_d = ext_we ? S_WR : S_RD;
                end else if (!prog_mode) begin
                    state_d = S_RESTART;
                end
            end
            S_WR: begin
                if (wr_count_q < WR_COUNT_MAX) wr_count_d = wr_count_q + 5'd1;
                state_d = S_ACK;
            end
            S_RD: begin
                rdata_d = ram_rdata;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (!ext_req) state_d = S_IDLE;
            end
            S_RESTART: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; clr is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= S_RUN;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            rdata_q       <= '0;
            wr_count_q    <= '0;
            run_en_q      <= 1'b1;
            cpu_clr_q     <= 1'b0;
            prog_active_q <= 1'b0;
            ack_q         <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_rd_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            rdata_q       <= rdata_d;
            wr_count_q    <= wr_count_d;
            run_en_q      <= (state_d == S_RUN) || (state_d == S_DRAIN);
            cpu_clr_q     <= (state_d == S_RESTART);
            prog_active_q <= (state_d != S_RUN);
            ack_q         <= (state_d == S_ACK);
            ram_we_q      <= (state_d == S_WR);
            ram_rd_q      <= (state_d == S_RD);
        end
    end

    // While the CPU runs the RAM pins are a straight pass-through of the MAR/controller.
    assign ram_addr    = run_en_q ? cpu_addr : addr_q;
    assign ram_ce_n    = run_en_q ? cpu_ce_n : ~ram_rd_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = wdata_q;

    assign ext_ack     = ack_q;
    assign ext_rdata   = rdata_q;
    assign cpu_run_en  = run_en_q;
    assign cpu_clr     = cpu_clr_q;
    assign prog_active = prog_active_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_sap_mem_arbiter.sv
// Self-checking bench for sap_mem_arbiter: directed protocol steps plus randomized loader
// traffic checked against a RAM-contents scoreboard and a saturating write tally.
module tb_sap_mem_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic       prog_mode;
    logic       ext_req;
    logic       ext_we;
    logic [3:0] ext_addr;
    logic [7:0] ext_wdata;
    logic       ext_ack;
    logic [7:0] ext_rdata;
    logic [3:0] cpu_addr;
    logic       cpu_ce_n;
    logic       cpu_last;
    logic       cpu_hlt_n;
    logic       cpu_run_en;
    logic       cpu_clr;
    logic [3:0] ram_addr;
    logic       ram_ce_n;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       prog_active;
    logic [4:0] wr_count;

    int vectors     = 0;
    int miscompares = 0;

    // Physical RAM seen by the DUT, and the bench's own record of what it should hold.
    logic [7:0] env_mem [16];
    logic [7:0] ref_mem [16];
    bit         ref_valid [16];
    int         ref_writes;

    sap_mem_arbiter dut (
        .clk         (clk),
        .clr         (clr),
        .prog_mode   (prog_mode),
        .ext_req     (ext_req),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_ack     (ext_ack),
        .ext_rdata   (ext_rdata),
        .cpu_addr    (cpu_addr),
        .cpu_ce_n    (cpu_ce_n),
        .cpu_last    (cpu_last),
        .cpu_hlt_n   (cpu_hlt_n),
        .cpu_run_en  (cpu_run_en),
        .cpu_clr     (cpu_clr),
        .ram_addr    (ram_addr),
        .ram_ce_n    (ram_ce_n),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .prog_active (prog_active),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) env_mem[ram_addr] <= ram_wdata;
    end

    assign ram_rdata = env_mem[ram_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic int expected_count();
        return (ref_writes > 16) ? 16 : ref_writes;
    endfunction

    task automatic enter_via_last(input int wait_cycles);
        prog_mode = 1'b1;
        cpu_last  = 1'b0;
        cpu_hlt_n = 1'b1;
        step();
        check("entry_prog_active", prog_active, 1);
        check("entry_run_en_drain", cpu_run_en, 1);
        ext_req  = 1'b1;
        cpu_addr = 4'($urandom);
        for (int i = 1; i < wait_cycles; i++) begin
            step();
            check("drain_run_en", cpu_run_en, 1);
            check("drain_no_ack", ext_ack, 0);
            check("drain_ram_follow", ram_addr, cpu_addr);
        end
        cpu_last = 1'b1;
        ext_req  = 1'b0;
        step();
        cpu_last   = 1'b0;
        ref_writes = 0;
        check("parked_run_en", cpu_run_en, 0);
        check("parked_prog_active", prog_active, 1);
        check("parked_wr_count", wr_count, 0);
    endtask

    task automatic enter_via_halt();
        cpu_hlt_n = 1'b0;
        cpu_last  = 1'b0;
        prog_mode = 1'b1;
        step();
        check("halt_drain_run_en", cpu_run_en, 1);
        check("halt_drain_prog_active", prog_active, 1);
        step();
        cpu_hlt_n  = 1'b1;
        ref_writes = 0;
        check("halt_parked_run_en", cpu_run_en, 0);
        check("halt_wr_count_clear", wr_count, 0);
    endtask

    task automatic xact(input logic we, input logic [3:0] addr, input logic [7:0] data,
                        input int hold, input bit drop_prog);
        ext_req   = 1'b1;
        ext_we    = we;
        ext_addr  = addr;
        ext_wdata = data;
        cpu_addr  = 4'($urandom);
        cpu_ce_n  = 1'($urandom);
        step();
        ext_we    = ~we;
        ext_addr  = ~addr;
        ext_wdata = ~data;
        check("xact_no_early_ack", ext_ack, 0);
        check("xact_ram_addr", ram_addr, addr);
        if (we) begin
            check("wr_strobe", ram_we, 1);
            check("wr_data", ram_wdata, data);
            ref_mem[addr]   = data;
            ref_valid[addr] = 1'b1;
            ref_writes++;
        end else begin
            check("rd_no_strobe", ram_we, 0);
            check("rd_ce_n", ram_ce_n, 0);
        end
        step();
        check("ack_rise", ext_ack, 1);
        check("wr_single_cycle", ram_we, 0);
        check("wr_count", wr_count, expected_count());
        if (!we) check("rd_data", ext_rdata, ref_mem[addr]);
        if (drop_prog) prog_mode = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            check("ack_hold", ext_ack, 1);
            check("hold_no_rewrite", ram_we, 0);
            check("hold_no_restart", cpu_clr, 0);
            if (!we) check("rd_data_held", ext_rdata, ref_mem[addr]);
        end
        ext_req = 1'b0;
        step();
        check("ack_fall", ext_ack, 0);
        check("wr_count_after", wr_count, expected_count());
    endtask

    task automatic expect_restart();
        step();
        check("restart_pulse", cpu_clr, 1);
        check("restart_run_en", cpu_run_en, 0);
        check("restart_prog_active", prog_active, 1);
        step();
        check("run_clr_low", cpu_clr, 0);
        check("run_run_en", cpu_run_en, 1);
        check("run_prog_active", prog_active, 0);
        cpu_addr = 4'($urandom);
        cpu_ce_n = 1'($urandom);
        #1;
        check("run_follow_addr", ram_addr, cpu_addr);
        check("run_follow_ce", ram_ce_n, cpu_ce_n);
        step();
        check("restart_single_pulse", cpu_clr, 0);
    endtask

    initial begin
        logic [3:0] a;
        clr        = 1'b1;
        prog_mode  = 1'b0;
        ext_req    = 1'b0;
        ext_we     = 1'b0;
        ext_addr   = '0;
        ext_wdata  = '0;
        cpu_addr   = 4'h5;
        cpu_ce_n   = 1'b0;
        cpu_last   = 1'b0;
        cpu_hlt_n  = 1'b1;
        ref_writes = 0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]   = '0;
            ref_valid[i] = 1'b0;
        end

        step(2);
        check("rst_ext_ack", ext_ack, 0);
        check("rst_ext_rdata", ext_rdata, 0);
        check("rst_run_en", cpu_run_en, 1);
        check("rst_cpu_clr", cpu_clr, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_ram_ce_follow", ram_ce_n, 0);
        check("rst_ram_addr_follow", ram_addr, 4'h5);
        check("rst_prog_active", prog_active, 0);
        check("rst_wr_count", wr_count, 0);
        clr = 1'b0;

        // Loader requests while running are ignored and the RAM tracks the CPU.
        for (int i = 0; i < 4; i++) begin
            ext_req  = 1'b1;
            cpu_addr = 4'($urandom);
            cpu_ce_n = 1'($urandom);
            step();
            check("run_ram_addr", ram_addr, cpu_addr);
            check("run_ram_ce_n", ram_ce_n, cpu_ce_n);
            check("run_ignore_req", ext_ack, 0);
            check("run_no_we", ram_we, 0);
            check("run_not_active", prog_active, 0);
        end
        ext_req = 1'b0;

        enter_via_last(3);

        xact(1'b1, 4'hA, 8'h3C, 5, 1'b0);
        check("handshake_one_write", wr_count, 1);
        xact(1'b0, 4'hA, 8'h00, 1, 1'b0);

        for (int i = 0; i < 17; i++) begin
            xact(1'b1, 4'($urandom), 8'($urandom), $urandom_range(0, 2), 1'b0);
        end
        check("wr_count_saturated", wr_count, 16);

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                xact(1'b1, 4'($urandom), 8'($urandom), $urandom_range(0, 2), 1'b0);
            end else begin
                a = 4'($urandom);
                if (!ref_valid[a]) a = 4'hA;
                xact(1'b0, a, 8'($urandom), $urandom_range(0, 2), 1'b0);
            end
        end

        // prog_mode falls while the handshake is still in ACK.
        xact(1'b1, 4'($urandom), 8'($urandom), 3, 1'b1);
        check("mid_exit_idle_no_clr", cpu_clr, 0);
        check("mid_exit_idle_active", prog_active, 1);
        expect_restart();

        // Re-entry clears the tally; a request beats a simultaneously falling prog_mode.
        enter_via_halt();
        prog_mode = 1'b0;
        xact(1'b1, 4'($urandom), 8'($urandom), 0, 1'b0);
        check("reentry_wr_count", wr_count, 1);
        expect_restart();

        // prog_mode withdrawn during DRAIN: the drain completes, then a restart.
        prog_mode = 1'b1;
        step();
        prog_mode = 1'b0;
        step(2);
        check("drain_fall_run_en", cpu_run_en, 1);
        check("drain_fall_active", prog_active, 1);
        cpu_last = 1'b1;
        step();
        cpu_last = 1'b0;
        check("drain_fall_parked", cpu_run_en, 0);
        expect_restart();

        // Reset while a write is in progress.
        enter_via_halt();
        ext_req   = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = 4'h3;
        ext_wdata = 8'h77;
        step();
        check("rst_mid_wr_strobe", ram_we, 1);
        clr     = 1'b1;
        ext_req = 1'b0;
        step();
        check("rst_mid_ack", ext_ack, 0);
        check("rst_mid_we", ram_we, 0);
        check("rst_mid_wr_count", wr_count, 0);
        check("rst_mid_run_en", cpu_run_en, 1);
        check("rst_mid_prog_active", prog_active, 0);
        clr = 1'b0;
        step(2);
        check("rst_mid_no_pending_we", ram_we, 0);
        check("rst_mid_no_late_ack", ext_ack, 0);
        check("rst_mid_still_run", cpu_run_en, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
